pico_s2p_receiver: RTL and testbench

Serial-to-parallel receiver for the controller-to-peripheral (PICO) half of the PSEC5 slow-control serial link. It deserializes LSB-first bytes on `sclk`: the first byte after reset is a register address, and every following byte is write data. It drives the address to the readback mux and issues one-cycle write strobes into the 59-entry register bank, auto-incrementing the address for burst writes. It is the counterpart of the POCI readback path (address mux plus parallel-to-serial shifter), which shares its bit order and address map.

---
 rtl/pico_s2p_receiver_pkg.sv | 26 ++
 rtl/pico_s2p_receiver_if.sv | 43 ++++
 rtl/pico_s2p_receiver_shift_register.sv | 46 ++++
 rtl/pico_s2p_receiver.sv | 126 ++++++++++++
 tb/tb_pico_s2p_receiver.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pico_s2p_receiver_pkg.sv
// +--------------------------------------------------------------------------+
// | psec5_spi_pkg: shared constants, receiver state type, address check.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package psec5_spi_pkg;

  localparam int unsigned NUM_REGS      = 59;
  localparam int unsigned RESERVED_ADDR = 0;
  localparam int unsigned BYTE_W        = 8;

  typedef enum logic [0:0] {
    S_ADDR = 1'b0,
    S_DATA = 1'b1
  } rx_state_t;

  // Address 0 is reserved; anything above the bank size has no register behind it.
  function automatic logic addr_is_valid(input logic [BYTE_W-1:0] addr,
                                         input int unsigned max_addr = NUM_REGS);
    return (32'(addr) != RESERVED_ADDR) && (32'(addr) <= max_addr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pico_s2p_receiver_if.sv
// +--------------------------------------------------------------------------+
// | pico_s2p_receiver_if: serial input and register-bank write/address side. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pico_s2p_receiver_if #(
  parameter int unsigned BYTE_W = psec5_spi_pkg::BYTE_W
);

  logic              pico;
  logic [BYTE_W-1:0] addr_out;
  logic              addr_valid;
  logic [BYTE_W-1:0] wr_addr;
  logic [BYTE_W-1:0] wr_data;
  logic              wr_en;
  logic              addr_err;

  // Controller / environment side.
  modport master (
    output pico,
    input  addr_out,
    input  addr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_en,
    input  addr_err
  );

  // Receiver side.
  modport slave (
    input  pico,
    output addr_out,
    output addr_valid,
    output wr_addr,
    output wr_data,
    output wr_en,
    output addr_err
  );

endinterface

`default_nettype wire

// File: rtl/pico_s2p_receiver_shift_register.sv
// +--------------------------------------------------------------------------+
// | s2p_shift_register: LSB-first serial shift-in with byte-complete flag.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module s2p_shift_register #(
  parameter int unsigned BYTE_W = psec5_spi_pkg::BYTE_W
) (
  input  wire logic              sclk,
  input  wire logic              rstn,
  input  wire logic              pico,
  output logic      [BYTE_W-1:0] byte_out,
  output logic                   byte_done
);

  localparam int unsigned C_CNT_W = $clog2(BYTE_W);
  localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(BYTE_W - 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic [BYTE_W-2:0]  r_shift;

  // Only BYTE_W-1 bits are stored: the final bit is taken straight from the
  // line so the assembled byte is usable on the edge that samples it.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_shift <= {pico, r_shift[BYTE_W-2:1]};
      if (r_cnt == C_LAST_BIT) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    byte_out  = {pico, r_shift};
    byte_done = (r_cnt == C_LAST_BIT);
  end

endmodule

`default_nettype wire

// File: rtl/pico_s2p_receiver.sv
// +--------------------------------------------------------------------------+
// | pico_s2p_receiver: PICO deserializer, address capture and burst writes.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pico_s2p_receiver #(
  parameter int unsigned NUM_REGS = psec5_spi_pkg::NUM_REGS,
  parameter int unsigned BYTE_W   = psec5_spi_pkg::BYTE_W
) (
  input  wire logic          sclk,
  input  wire logic          rstn,
  pico_s2p_receiver_if.slave bus
);

  import psec5_spi_pkg::rx_state_t;
  import psec5_spi_pkg::S_ADDR;
  import psec5_spi_pkg::S_DATA;
  import psec5_spi_pkg::addr_is_valid;

  localparam logic [BYTE_W-1:0] C_MAX_ADDR   = BYTE_W'(NUM_REGS);
  localparam logic [BYTE_W-1:0] C_FIRST_ADDR = BYTE_W'(1);

  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [BYTE_W-1:0] r_addr;
  logic [BYTE_W-1:0] w_addr_nxt;
  logic              r_addr_valid;
  logic              w_addr_valid_nxt;
  logic              r_addr_err;
  logic              w_addr_err_nxt;
  logic              r_wr_en;
  logic              w_wr_en_nxt;
  logic [BYTE_W-1:0] r_wr_addr;
  logic [BYTE_W-1:0] w_wr_addr_nxt;
  logic [BYTE_W-1:0] r_wr_data;
  logic [BYTE_W-1:0] w_wr_data_nxt;

  logic [BYTE_W-1:0] w_byte;
  logic              w_byte_done;
  logic [BYTE_W-1:0] w_addr_inc;

  s2p_shift_register #(
    .BYTE_W (BYTE_W)
  ) u_shift (
    .sclk      (sclk),
    .rstn      (rstn),
    .pico      (bus.pico),
    .byte_out  (w_byte),
    .byte_done (w_byte_done)
  );

  // Burst increment skips the reserved address on wrap.
  always_comb begin
    if (r_addr >= C_MAX_ADDR) begin
      w_addr_inc = C_FIRST_ADDR;
    end else begin
      w_addr_inc = r_addr + C_FIRST_ADDR;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_addr_valid_nxt = r_addr_valid;
    w_addr_err_nxt   = r_addr_err;
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;

    if (w_byte_done) begin
      case (r_state)
        S_ADDR: begin
          w_addr_nxt       = w_byte;
          w_addr_valid_nxt = 1'b1;
          w_addr_err_nxt   = r_addr_err | ~addr_is_valid(w_byte, NUM_REGS);
          w_state_nxt      = S_DATA;
        end
        S_DATA: begin
          // A bad address blocks every write until the next reset.
          if (!r_addr_err) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = r_addr;
            w_wr_data_nxt = w_byte;
            w_addr_nxt    = w_addr_inc;
          end
        end
        default: begin
          w_state_nxt = S_ADDR;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_ADDR;
      r_addr       <= '0;
      r_addr_valid <= 1'b0;
      r_addr_err   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_addr_valid <= w_addr_valid_nxt;
      r_addr_err   <= w_addr_err_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
    end
  end

  always_comb begin
    bus.addr_out   = r_addr;
    bus.addr_valid = r_addr_valid;
    bus.addr_err   = r_addr_err;
    bus.wr_en      = r_wr_en;
    bus.wr_addr    = r_wr_addr;
    bus.wr_data    = r_wr_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_pico_s2p_receiver.sv
// +--------------------------------------------------------------------------+
// | tb_pico_s2p_receiver: self-checking bench with register bank and shifter.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pico_s2p_receiver;

  localparam int unsigned C_NREG = 59;

  logic sclk;
  logic rstn;
  int   checks;
  int   errors;
  logic [7:0] bank [0:C_NREG];

  pico_s2p_receiver_if #(.BYTE_W(8)) bus ();

  pico_s2p_receiver #(
    .NUM_REGS (C_NREG),
    .BYTE_W   (8)
  ) dut (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Register bank that samples the strobe on the following edge.
  always @(posedge sclk) begin
    if (bus.wr_en && bus.wr_addr != 8'd0 && bus.wr_addr <= 8'(C_NREG))
      bank[bus.wr_addr] <= bus.wr_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reset from just after an edge; the next edge samples bit 0.
  task automatic do_reset;
    rstn     = 1'b0;
    bus.pico = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    rstn = 1'b1;
  endtask

  // Sends n LSB-first bits; counts strobes on every edge but the 8th bit's.
  task automatic send_bits(input logic [7:0] b, input int n, output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      bus.pico = b[i];
      @(posedge sclk);
      #1;
      if (i != 7 && bus.wr_en) early++;
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({bus.addr_out, bus.addr_valid, bus.addr_err, bus.wr_en, bus.wr_addr, bus.wr_data} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%0h v=%0b e=%0b en=%0b wa=%0h wd=%0h required all 0",
               bus.addr_out, bus.addr_valid, bus.addr_err, bus.wr_en, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_single_write;
    int early;
    do_reset;
    send_bits(8'd5, 8, early);
    checks++;
    if (bus.addr_out !== 8'd5 || bus.addr_valid !== 1'b1 || bus.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL single_addr: got a=%0d v=%0b e=%0b required a=5 v=1 e=0",
               bus.addr_out, bus.addr_valid, bus.addr_err);
    end
    send_bits(8'hA3, 8, early);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd5 || bus.wr_data !== 8'hA3 || bus.addr_out !== 8'd6) begin
      errors++;
      $display("FAIL single_write: got en=%0b wa=%0d wd=%0h a=%0d required en=1 wa=5 wd=a3 a=6",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.addr_out);
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL single_early: got %0d strobes before byte end required 0", early);
    end
    @(posedge sclk);
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_data !== 8'hA3) begin
      errors++;
      $display("FAIL single_pulse_width: got en=%0b wd=%0h required en=0 wd=a3", bus.wr_en, bus.wr_data);
    end
  endtask

  task automatic test_burst_wrap;
    int early;
    logic [7:0] data [3];
    logic [7:0] exp_wa [3];
    data   = '{8'h11, 8'h22, 8'h33};
    exp_wa = '{8'd58, 8'd59, 8'd1};
    do_reset;
    send_bits(8'd58, 8, early);
    for (int k = 0; k < 3; k++) begin
      send_bits(data[k], 8, early);
      checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== exp_wa[k] || bus.wr_data !== data[k] || early !== 0) begin
        errors++;
        $display("FAIL burst_write%0d: got en=%0b wa=%0d wd=%0h early=%0d required en=1 wa=%0d wd=%0h early=0",
                 k, bus.wr_en, bus.wr_addr, bus.wr_data, early, exp_wa[k], data[k]);
      end
    end
    checks++;
    if (bus.addr_out !== 8'd2) begin
      errors++;
      $display("FAIL burst_final_addr: got %0d required 2", bus.addr_out);
    end
  endtask

  task automatic test_invalid_addr;
    int early;
    logic [7:0] bad [2];
    bad = '{8'd0, 8'd60};
    for (int t = 0; t < 2; t++) begin
      do_reset;
      send_bits(bad[t], 8, early);
      checks++;
      if (bus.addr_err !== 1'b1 || bus.addr_out !== bad[t] || bus.addr_valid !== 1'b1) begin
        errors++;
        $display("FAIL invalid_addr%0d: got err=%0b a=%0d v=%0b required err=1 a=%0d v=1",
                 t, bus.addr_err, bus.addr_out, bus.addr_valid, bad[t]);
      end
      for (int k = 0; k < 2; k++) begin
        send_bits(8'($urandom), 8, early);
        checks++;
        if (bus.wr_en !== 1'b0 || early !== 0 || bus.addr_out !== bad[t] || bus.addr_err !== 1'b1) begin
          errors++;
          $display("FAIL invalid_nowrite%0d_%0d: got en=%0b early=%0d a=%0d err=%0b required en=0 early=0 a=%0d err=1",
                   t, k, bus.wr_en, early, bus.addr_out, bus.addr_err, bad[t]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_data;
    int early;
    do_reset;
    send_bits(8'd10, 8, early);
    send_bits(8'h5A, 5, early);
    rstn = 1'b0;
    #1;
    checks++;
    if (early !== 0 || {bus.addr_out, bus.addr_valid, bus.addr_err, bus.wr_en, bus.wr_addr, bus.wr_data} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: got early=%0d a=%0d v=%0b en=%0b required all 0",
               early, bus.addr_out, bus.addr_valid, bus.wr_en);
    end
    do_reset;
    send_bits(8'd3, 8, early);
    send_bits(8'hFF, 8, early);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd3 || bus.wr_data !== 8'hFF || early !== 0) begin
      errors++;
      $display("FAIL mid_reset_rewrite: got en=%0b wa=%0d wd=%0h early=%0d required en=1 wa=3 wd=ff early=0",
               bus.wr_en, bus.wr_addr, bus.wr_data, early);
    end
  endtask

  task automatic test_reset_on_complete;
    int early;
    int seen;
    do_reset;
    send_bits(8'd7, 8, early);
    send_bits(8'hC6, 7, early);
    @(negedge sclk);
    bus.pico = 1'b1;
    rstn     = 1'b0;
    seen     = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge sclk);
      #1;
      if (bus.wr_en) seen++;
    end
    checks++;
    if (seen !== 0 || early !== 0 || {bus.addr_out, bus.addr_valid, bus.wr_addr, bus.wr_data} !== 25'd0) begin
      errors++;
      $display("FAIL reset_on_complete: got strobes=%0d early=%0d a=%0d wa=%0d wd=%0h required no strobe, all 0",
               seen, early, bus.addr_out, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_readback;
    int early;
    logic [7:0] sh;
    logic [7:0] got;
    do_reset;
    send_bits(8'd12, 8, early);
    send_bits(8'h5C, 8, early);
    @(posedge sclk);
    #1;
    do_reset;
    send_bits(8'd12, 8, early);
    checks++;
    if (bus.addr_out !== 8'd12) begin
      errors++;
      $display("FAIL readback_addr: got %0d required 12", bus.addr_out);
    end
    // POCI shifter: loaded from the mux after edge 8, LSB out first.
    sh  = (bus.addr_out == 8'd0 || bus.addr_out > 8'(C_NREG)) ? 8'd0 : bank[bus.addr_out];
    got = 8'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sclk);
      #1;
      got = {sh[0], got[7:1]};
      sh  = sh >> 1;
    end
    checks++;
    if (got !== 8'h5C) begin
      errors++;
      $display("FAIL readback_serial: got %0h required 5c", got);
    end
  endtask

  task automatic test_random;
    int early;
    int unsigned a;
    int unsigned cur;
    int nbytes;
    logic ok;
    logic [7:0] d;
    for (int t = 0; t < 14; t++) begin
      a      = (t % 4 == 0) ? $urandom_range(0, 255) : $urandom_range(50, 59);
      nbytes = $urandom_range(1, 12);
      ok     = (a >= 1 && a <= C_NREG);
      cur    = a;
      do_reset;
      send_bits(8'(a), 8, early);
      checks++;
      if (bus.addr_out !== 8'(a) || bus.addr_valid !== 1'b1 || bus.addr_err !== !ok || early !== 0) begin
        errors++;
        $display("FAIL rand_addr%0d: got a=%0d v=%0b err=%0b required a=%0d v=1 err=%0b",
                 t, bus.addr_out, bus.addr_valid, bus.addr_err, a, !ok);
      end
      for (int k = 0; k < nbytes; k++) begin
        d = 8'($urandom);
        send_bits(d, 8, early);
        checks++;
        if (ok) begin
          if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'(cur) || bus.wr_data !== d || early !== 0 ||
              bus.addr_out !== 8'(cur % C_NREG + 1)) begin
            errors++;
            $display("FAIL rand_write%0d_%0d: got en=%0b wa=%0d wd=%0h a=%0d early=%0d required en=1 wa=%0d wd=%0h a=%0d",
                     t, k, bus.wr_en, bus.wr_addr, bus.wr_data, bus.addr_out, early, cur, d, cur % C_NREG + 1);
          end
          cur = cur % C_NREG + 1;
        end else begin
          if (bus.wr_en !== 1'b0 || early !== 0 || bus.addr_out !== 8'(a)) begin
            errors++;
            $display("FAIL rand_blocked%0d_%0d: got en=%0b early=%0d a=%0d required en=0 a=%0d",
                     t, k, bus.wr_en, early, bus.addr_out, a);
          end
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    bus.pico = 1'b0;
    for (int i = 0; i <= int'(C_NREG); i++) bank[i] = 8'd0;
    test_reset;
    test_single_write;
    test_burst_wrap;
    test_invalid_addr;
    test_reset_mid_data;
    test_reset_on_complete;
    test_readback;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
